// File: rtl/mem_pkg.sv
// mem_pkg: default sizes, the request record and the FSM state type shared by
// the memory request controller and its request FIFO.
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 3;
    localparam int MEM_DEPTH  = 6;

    typedef struct packed {
        logic                  rd_wr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wr_data;
    } mem_req_t;

    localparam int REQ_W = $bits(mem_req_t);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: FIFO_DEPTH-entry request buffer (any depth, not only powers of 2);
// pointers wrap explicitly and the occupancy count saturates at both ends.
module mem_req_fifo
    import mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset1_n,
    input  logic             push_i,
    input  logic [REQ_W-1:0] push_data_i,
    input  logic             pop_i,
    output logic [REQ_W-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    mem_req_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o     = (cnt_q == FULL_CNT);
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= mem_req_t'(push_data_i);
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request front end for the 6x8 register memory.
// Define MEM_ADDR_CHK_EN to answer out-of-range addresses with rsp_err instead of issuing them.
//   IDLE    | waiting; pops the FIFO head into the command register
//   ISSUE   | drives the command onto the memory port for one edge
//   CAPTURE | memory read data valid; latched into the response register
//   RESP    | response held valid until rsp_ready
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W     = MEM_DATA_W,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DEPTH      = MEM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset1_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rd_data,
    output logic              rsp_err,
    output logic              mem_reset1,
    output logic              mem_rd_wr1,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [DATA_W-1:0] mem_wr_data1,
    input  logic [DATA_W-1:0] mem_rd_data1
);

`ifdef MEM_ADDR_CHK_EN
    localparam logic ADDR_CHK = 1'b1;
`else
    localparam logic ADDR_CHK = 1'b0;
`endif
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    mem_state_e        state_q, state_d;
    mem_req_t          cmd_q, head;
    logic [REQ_W-1:0]  head_raw;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q, head_err;
    logic              rst_sync_q, mem_reset_q;
    logic              push, pop, full, empty;

    // Memory reset asserts with reset1_n and releases two edges later.
    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) begin
            rst_sync_q  <= 1'b1;
            mem_reset_q <= 1'b1;
        end else begin
            rst_sync_q  <= 1'b0;
            mem_reset_q <= rst_sync_q;
        end
    end

    assign mem_reset1 = mem_reset_q;
    assign req_ready  = !full && !mem_reset_q;
    assign push       = req_valid && req_ready;

    mem_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset1_n    (reset1_n),
        .push_i      (push),
        .push_data_i ({req_rd_wr, req_addr, req_wr_data}),
        .pop_i       (pop),
        .pop_data_o  (head_raw),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign head     = mem_req_t'(head_raw);
    assign head_err = ADDR_CHK && ({1'b0, head.addr} >= DEPTH_EXT);

    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = head_err ? RESP : ISSUE;
            ISSUE:   state_d = cmd_q.rd_wr ? CAPTURE : RESP;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        rsp_valid  = 1'b0;
        mem_rd_wr1 = 1'b1;
        case (state_q)
            IDLE:    pop = !empty;
            ISSUE:   mem_rd_wr1 = cmd_q.rd_wr;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset1_n) begin
        if (!reset1_n) begin
            cmd_q      <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
        end else if (pop) begin
            cmd_q      <= head;
            err_q      <= head_err;
            rsp_data_q <= '0;
        end else if (state_q == CAPTURE) begin
            rsp_data_q <= mem_rd_data1;
        end
    end

    assign mem_addr1    = cmd_q.addr;
    assign mem_wr_data1 = cmd_q.wr_data;
    assign rsp_rd_data  = rsp_data_q;
    assign rsp_err      = err_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and randomized checks of mem_req_ctrl, with a behavioural
// 6x8 memory and an array/queue reference of the expected responses.
module tb_mem_req_ctrl;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int DEP = 6;
`ifdef MEM_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset1_n;
    logic          req_valid, req_ready, req_rd_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wr_data;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rd_data;
    logic          mem_reset1, mem_rd_wr1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wr_data1, mem_rd_data1;

    always #5 clk = ~clk;

    mem_req_ctrl dut (
        .clk          (clk),
        .reset1_n     (reset1_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd_wr    (req_rd_wr),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd_data  (rsp_rd_data),
        .rsp_err      (rsp_err),
        .mem_reset1   (mem_reset1),
        .mem_rd_wr1   (mem_rd_wr1),
        .mem_addr1    (mem_addr1),
        .mem_wr_data1 (mem_wr_data1),
        .mem_rd_data1 (mem_rd_data1)
    );

    // Register memory: acts on every edge, resets to all-ones.
    logic [DW-1:0] mem_arr [DEP];
    always @(posedge clk) begin
        if (mem_reset1) begin
            for (int i = 0; i < DEP; i++) mem_arr[i] <= 8'hFF;
        end else if (!mem_rd_wr1 && int'(mem_addr1) < DEP) begin
            mem_arr[mem_addr1] <= mem_wr_data1;
        end
        mem_rd_data1 <= (int'(mem_addr1) < DEP) ? mem_arr[mem_addr1] : 8'h00;
    end

    int cyc = 0;
    int wr_low_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (!mem_rd_wr1) wr_low_cnt <= wr_low_cnt + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        bit            chk_data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [8];
    int            n_tests = 0;
    int            n_fail = 0;
    int            last_acc_cyc = 0;

    task automatic tchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'hFF;
        exp_q.delete();
    endtask

    // Responses are in request order, so applying requests to the reference
    // in acceptance order yields every expected response.
    task automatic predict(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        int   ai;
        ai         = int'(a);
        e.err      = CHK && (ai >= DEP);
        e.chk_data = 1'b1;
        e.data     = '0;
        if (!e.err) begin
            if (rw) begin
                e.data     = ref_mem[ai];
                e.chk_data = (ai < DEP);
            end else if (ai < DEP) begin
                ref_mem[ai] = d;
            end
        end
        exp_q.push_back(e);
    endtask

    // One clock: check any visible response, advance, then book any acceptance.
    task automatic step();
        bit            acc, cons;
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        acc  = req_valid && req_ready;
        cons = rsp_valid && rsp_ready;
        rw   = req_rd_wr;
        a    = req_addr;
        d    = req_wr_data;
        if (rsp_valid) begin
            tchk("rsp_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                if (exp_q[0].chk_data) tchk("rsp_rd_data", 32'(rsp_rd_data), 32'(exp_q[0].data));
                tchk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
                if (cons) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (acc) begin
            predict(rw, a, d);
            last_acc_cyc = cyc;
            req_valid    = 1'b0;
        end
    endtask

    task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        req_valid   = 1'b1;
        req_rd_wr   = rw;
        req_addr    = a;
        req_wr_data = d;
        while (req_valid && n < 40) begin
            step();
            n++;
        end
        tchk("req_accept_timeout", 32'(req_valid), 32'(0));
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        tchk("rsp_wait_timeout", 32'(rsp_valid), 32'(1));
        lat = cyc - last_acc_cyc;
    endtask

    task automatic txn(input string tag, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_lat);
        int lat;
        send(rw, a, d);
        wait_rsp(lat);
        tchk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        int lat;
        reset1_n    = 1'b1;
        req_valid   = 1'b0;
        req_rd_wr   = 1'b0;
        req_addr    = '0;
        req_wr_data = '0;
        rsp_ready   = 1'b0;
        ref_reset();

        // Reset values, then release and the two-edge memory reset tail
        #1 reset1_n = 1'b0;
        #1;
        tchk("rst_req_ready",    32'(req_ready),    32'(0));
        tchk("rst_rsp_valid",    32'(rsp_valid),    32'(0));
        tchk("rst_rsp_rd_data",  32'(rsp_rd_data),  32'(0));
        tchk("rst_rsp_err",      32'(rsp_err),      32'(0));
        tchk("rst_mem_reset1",   32'(mem_reset1),   32'(1));
        tchk("rst_mem_rd_wr1",   32'(mem_rd_wr1),   32'(1));
        tchk("rst_mem_addr1",    32'(mem_addr1),    32'(0));
        tchk("rst_mem_wr_data1", 32'(mem_wr_data1), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset1_n = 1'b1;
        @(posedge clk);
        #1;
        tchk("mem_reset1_edge1", 32'(mem_reset1), 32'(1));
        tchk("req_ready_edge1",  32'(req_ready),  32'(0));
        @(posedge clk);
        #1;
        tchk("mem_reset1_edge2", 32'(mem_reset1), 32'(0));
        tchk("req_ready_edge2",  32'(req_ready),  32'(1));

        txn("rd3_after_reset", 1'b1, 3'd3, 8'h00, 3);

        txn("wr2_a5", 1'b0, 3'd2, 8'hA5, 2);
        txn("rd2_a5", 1'b1, 3'd2, 8'h00, 3);

        // Backpressure: five fit (command register + FIFO), the sixth waits
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tchk("bp_ready_before", 32'(req_ready), 32'(1));
            send(1'b0, AW'(i), DW'($urandom));
        end
        tchk("bp_ready_after5", 32'(req_ready), 32'(0));
        req_valid   = 1'b1;
        req_rd_wr   = 1'b1;
        req_addr    = 3'd0;
        req_wr_data = 8'h00;
        repeat (3) step();
        tchk("bp_sixth_held", 32'(req_valid), 32'(1));
        rsp_ready = 1'b1;
        n = 0;
        while ((req_valid || exp_q.size() > 0) && n < 60) begin
            step();
            n++;
        end
        tchk("bp_drain", 32'(exp_q.size()), 32'(0));
        tchk("bp_sixth_taken", 32'(req_valid), 32'(0));
        rsp_ready = 1'b0;

`ifdef MEM_ADDR_CHK_EN
        base = wr_low_cnt;
        txn("err_rd6", 1'b1, 3'd6, 8'h00, 1);
        txn("err_wr7", 1'b0, 3'd7, 8'h3C, 1);
        tchk("err_no_mem_write", 32'(wr_low_cnt - base), 32'(0));
`else
        send(1'b0, 3'd6, 8'h3C);
        step();
        tchk("off_issue_rd_wr1",   32'(mem_rd_wr1),   32'(0));
        tchk("off_issue_addr1",    32'(mem_addr1),    32'(6));
        tchk("off_issue_wr_data1", 32'(mem_wr_data1), 32'(8'h3C));
        wait_rsp(lat);
        tchk("off_wr6_latency", 32'(lat), 32'(2));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
`endif

        // Reset pulse while a read sits in CAPTURE
        txn("cap_wr2_5a", 1'b0, 3'd2, 8'h5A, 2);
        send(1'b1, 3'd2, 8'h00);
        step();
        step();
        reset1_n = 1'b0;
        #1;
        tchk("cap_rst_mem_reset1", 32'(mem_reset1), 32'(1));
        tchk("cap_rst_mem_rd_wr1", 32'(mem_rd_wr1), 32'(1));
        tchk("cap_rst_rsp_valid",  32'(rsp_valid),  32'(0));
        tchk("cap_rst_req_ready",  32'(req_ready),  32'(0));
        ref_reset();
        step();
        reset1_n  = 1'b1;
        rsp_ready = 1'b1;
        repeat (8) step();
        tchk("cap_no_rsp",      32'(rsp_valid), 32'(0));
        tchk("cap_ready_again", 32'(req_ready), 32'(1));
        rsp_ready = 1'b0;
        txn("cap_rd2_after", 1'b1, 3'd2, 8'h00, 3);

        // Randomized traffic with random response backpressure
        for (int k = 0; k < 400; k++) begin
            if (!req_valid && $urandom_range(0, 1) == 1) begin
                req_valid   = 1'b1;
                req_rd_wr   = 1'($urandom_range(0, 1));
                req_addr    = AW'($urandom_range(0, 7));
                req_wr_data = DW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        tchk("rand_drain", 32'(exp_q.size()), 32'(0));
        step();
        tchk("rand_idle", 32'(rsp_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
